// File: rtl/vga_pkg.sv
// Shared VGA constants: RGB332 colours, active-area limits and sprite renderer state encoding.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  localparam logic [COLOR_W-1:0] RGB_KEY_DEFAULT = 8'hE3;
  localparam logic [COLOR_W-1:0] RGB_BLACK = 8'h00;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } render_state_t;

endpackage

// File: rtl/pos_shadow.sv
// Sprite position double-buffer: pending takes writes, active updates only on frame_tick.
module pos_shadow
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               clr_n,
  input  logic               vsync,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               pos_we,
  output logic               frame_tick,
  output logic [COORD_W-1:0] act_x,
  output logic [COORD_W-1:0] act_y
);

  logic               vsync_d;
  logic [COORD_W-1:0] pend_x;
  logic [COORD_W-1:0] pend_y;

  // A write coinciding with frame_tick lands in pending; active takes the older value.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vsync_d    <= 1'b0;
      frame_tick <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      act_x      <= '0;
      act_y      <= '0;
    end else begin
      vsync_d    <= vsync;
      frame_tick <= vsync_d & ~vsync;
      if (pos_we) begin
        pend_x <= pos_x;
        pend_y <= pos_y;
      end
      if (frame_tick) begin
        act_x <= pend_x;
        act_y <= pend_y;
      end
    end
  end

endmodule

// File: rtl/sprite_render.sv
// Two-stage sprite overlay on the VGA raster with a synchronous sprite ROM.
// Optional colour-key transparency is enabled by defining SPRITE_TRANSPARENCY_EN.
module sprite_render
  import vga_pkg::*;
#(
  parameter int unsigned         SPR_W     = 64,
  parameter int unsigned         SPR_H     = 64,
  parameter logic [COLOR_W-1:0]  KEY_COLOR = RGB_KEY_DEFAULT
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               video_on,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               pos_we,
  output logic [11:0]        rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  input  logic [COLOR_W-1:0] bg_color,
  output logic [COLOR_W-1:0] rgb,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               frame_tick
);

  localparam int unsigned ADDR_W = 12;
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

  render_state_t      state;
  logic [COORD_W-1:0] act_x;
  logic [COORD_W-1:0] act_y;
  logic [COORD_W:0]   x_end_c;
  logic [COORD_W:0]   y_end_c;
  logic [COORD_W-1:0] dx_c;
  logic [COORD_W-1:0] dy_c;
  logic [ADDR_W-1:0]  addr_c;
  logic               hit_c;
  logic               opaque_c;
  logic               hit_d;
  logic               von_d;
  logic               hs_d;
  logic               vs_d;

  pos_shadow u_pos_shadow (
    .clk        (clk),
    .clr_n      (clr_n),
    .vsync      (vsync),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_we     (pos_we),
    .frame_tick (frame_tick),
    .act_x      (act_x),
    .act_y      (act_y)
  );

  // 11-bit end coordinates so sprites near 1023 do not wrap into a false hit.
  assign x_end_c = {1'b0, act_x} + (COORD_W+1)'(SPR_W);
  assign y_end_c = {1'b0, act_y} + (COORD_W+1)'(SPR_H);
  assign dx_c    = pixel_x - act_x;
  assign dy_c    = pixel_y - act_y;
  assign addr_c  = ADDR_W'(32'(dy_c) * SPR_W + 32'(dx_c));

  assign hit_c = video_on
              && (act_x < H_LIM) && (act_y < V_LIM)
              && (pixel_x < H_LIM) && (pixel_y < V_LIM)
              && (pixel_x >= act_x) && ({1'b0, pixel_x} < x_end_c)
              && (pixel_y >= act_y) && ({1'b0, pixel_y} < y_end_c);

`ifdef SPRITE_TRANSPARENCY_EN
  assign opaque_c = (rom_data != KEY_COLOR);
`else
  logic unused_key;
  assign unused_key = ^KEY_COLOR;
  assign opaque_c   = 1'b1;
`endif

  // State, address stage and colour stage; syncs ride alongside to stay aligned with rgb.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= WAIT_FRAME;
      rom_addr <= '0;
      hit_d    <= 1'b0;
      von_d    <= 1'b0;
      hs_d     <= 1'b0;
      vs_d     <= 1'b0;
      rgb      <= RGB_BLACK;
      hsync_o  <= 1'b0;
      vsync_o  <= 1'b0;
    end else begin
      if (state == WAIT_FRAME && frame_tick) begin
        state <= RUN;
      end
      rom_addr <= hit_c ? addr_c : '0;
      hit_d    <= hit_c;
      von_d    <= video_on;
      hs_d     <= hsync;
      vs_d     <= vsync;
      hsync_o  <= hs_d;
      vsync_o  <= vs_d;
      if (state == WAIT_FRAME || !von_d) begin
        rgb <= RGB_BLACK;
      end else if (hit_d && opaque_c) begin
        rgb <= rom_data;
      end else begin
        rgb <= bg_color;
      end
    end
  end

endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for sprite_render: vector tables for the pixel pipeline plus frame/reset sequences.
module tb_sprite_render;

  logic       clk;
  logic       clr_n;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       pos_we;
  logic [11:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] bg_color;
  logic [7:0] rgb;
  logic       hsync_o;
  logic       vsync_o;
  logic       frame_tick;

  int n_chk;
  int n_fail;

  localparam logic [7:0] BG = 8'h12;
`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic [7:0] EXP_KEY = BG;
`else
  localparam logic [7:0] EXP_KEY = 8'hE3;
`endif

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic        von;
    logic [7:0]  rd;
    logic [11:0] addr;
    logic [7:0]  rgb;
  } vec_t;

  vec_t va[8];
  vec_t vb[4];
  vec_t vc[2];

  sprite_render dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .video_on   (video_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_we     (pos_we),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .bg_color   (bg_color),
    .rgb        (rgb),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    pixel_x  = v.px;
    pixel_y  = v.py;
    video_on = v.von;
    step();
    chk({nm, "_addr"}, 32'(rom_addr), 32'(v.addr));
    rom_data = v.rd;
    video_on = 1'b0;
    pixel_x  = '0;
    pixel_y  = '0;
    step();
    chk({nm, "_rgb"}, 32'(rgb), 32'(v.rgb));
  endtask

  task automatic write_pos(input logic [9:0] x, input logic [9:0] y);
    pos_x  = x;
    pos_y  = y;
    pos_we = 1'b1;
    step();
    pos_we = 1'b0;
  endtask

  // vsync high then low; optionally write a position in the frame_tick cycle.
  task automatic vs_pulse(input logic we, input logic [9:0] x, input logic [9:0] y);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    chk("frame_tick_pulse", 32'(frame_tick), 32'd1);
    pos_we = we;
    pos_x  = x;
    pos_y  = y;
    step();
    pos_we = 1'b0;
    chk("frame_tick_clear", 32'(frame_tick), 32'd0);
  endtask

  initial begin
    logic hist[64];
    logic vhist[64];

    n_chk  = 0;
    n_fail = 0;

    va[0] = '{10'd100, 10'd50,  1'b1, 8'h5A, 12'd0,    8'h5A};
    va[1] = '{10'd163, 10'd113, 1'b1, 8'h33, 12'd4095, 8'h33};
    va[2] = '{10'd164, 10'd113, 1'b1, 8'h33, 12'd0,    BG};
    va[3] = '{10'd99,  10'd50,  1'b1, 8'h33, 12'd0,    BG};
    va[4] = '{10'd100, 10'd114, 1'b1, 8'h33, 12'd0,    BG};
    va[5] = '{10'd120, 10'd60,  1'b0, 8'h33, 12'd0,    8'h00};
    va[6] = '{10'd130, 10'd70,  1'b1, 8'hE3, 12'd1310, EXP_KEY};
    va[7] = '{10'd101, 10'd51,  1'b1, 8'hFF, 12'd65,   8'hFF};

    vb[0] = '{10'd639, 10'd479, 1'b1, 8'h77, 12'd1895, 8'h77};
    vb[1] = '{10'd599, 10'd450, 1'b1, 8'h77, 12'd0,    BG};
    vb[2] = '{10'd600, 10'd450, 1'b1, 8'h21, 12'd0,    8'h21};
    vb[3] = '{10'd200, 10'd200, 1'b1, 8'h21, 12'd0,    BG};

    vc[0] = '{10'd300, 10'd300, 1'b1, 8'h48, 12'd0,    8'h48};
    vc[1] = '{10'd299, 10'd300, 1'b1, 8'h48, 12'd0,    BG};

    clr_n    = 1'b0;
    video_on = 1'b0;
    hsync    = 1'b0;
    vsync    = 1'b0;
    pixel_x  = '0;
    pixel_y  = '0;
    pos_x    = '0;
    pos_y    = '0;
    pos_we   = 1'b0;
    rom_data = '0;
    bg_color = BG;
    repeat (2) step();
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_syncs", 32'({hsync_o, vsync_o, frame_tick}), 32'd0);
    clr_n = 1'b1;
    step();

    // First frame stays black even over a sprite hit.
    write_pos(10'd100, 10'd50);
    pixel_x  = 10'd10;
    pixel_y  = 10'd10;
    video_on = 1'b1;
    rom_data = 8'h55;
    step();
    step();
    chk("wait_frame_rgb", 32'(rgb), 32'd0);
    video_on = 1'b0;
    vs_pulse(1'b0, 10'd0, 10'd0);

    for (int i = 0; i < 8; i++) apply(va[i], $sformatf("va%0d", i));

    // Mid-frame writes must not move the rendered sprite; last write wins.
    write_pos(10'd200, 10'd200);
    apply(va[0], "midframe_unchanged");
    write_pos(10'd600, 10'd450);
    vs_pulse(1'b1, 10'd300, 10'd300);
    for (int i = 0; i < 4; i++) apply(vb[i], $sformatf("vb%0d", i));
    vs_pulse(1'b0, 10'd0, 10'd0);
    for (int i = 0; i < 2; i++) apply(vc[i], $sformatf("vc%0d", i));

    // Reset in the middle of a line with non-zero outputs.
    pixel_x  = 10'd310;
    pixel_y  = 10'd305;
    video_on = 1'b1;
    hsync    = 1'b1;
    vsync    = 1'b1;
    rom_data = 8'h44;
    step();
    step();
    chk("pre_rst_addr", 32'(rom_addr), 32'd330);
    chk("pre_rst_rgb", 32'(rgb), 32'h44);
    chk("pre_rst_syncs", 32'({hsync_o, vsync_o}), 32'd3);
    #5;
    clr_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'(rgb), 32'd0);
    chk("async_rst_addr", 32'(rom_addr), 32'd0);
    chk("async_rst_syncs", 32'({hsync_o, vsync_o, frame_tick}), 32'd0);
    hsync    = 1'b0;
    vsync    = 1'b0;
    video_on = 1'b0;
    step();
    clr_n = 1'b1;
    pixel_x  = 10'd10;
    pixel_y  = 10'd10;
    video_on = 1'b1;
    rom_data = 8'h66;
    step();
    chk("post_rst_wait_addr", 32'(rom_addr), 32'd650);
    step();
    chk("post_rst_wait_rgb", 32'(rgb), 32'd0);
    video_on = 1'b0;
    vs_pulse(1'b0, 10'd0, 10'd0);
    apply('{10'd10, 10'd10, 1'b1, 8'h66, 12'd650, 8'h66}, "post_rst_run");

    // Active position beyond the visible area never hits.
    write_pos(10'd700, 10'd10);
    vs_pulse(1'b0, 10'd0, 10'd0);
    apply('{10'd639, 10'd10, 1'b1, 8'h66, 12'd0, BG}, "clip_x");

    // Sync outputs equal inputs delayed by exactly two cycles.
    for (int i = 0; i < 40; i++) begin
      hsync    = 1'($urandom_range(0, 1));
      vsync    = 1'($urandom_range(0, 1));
      hist[i]  = hsync;
      vhist[i] = vsync;
      step();
      if (i >= 1) begin
        chk($sformatf("hsync_delay%0d", i), 32'(hsync_o), 32'(hist[i-1]));
        chk($sformatf("vsync_delay%0d", i), 32'(vsync_o), 32'(vhist[i-1]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_render.md
SPRITE_RENDER -- requirements
Module: sprite_render

Interface
REQ-001 SHALL have parameter SPR_W, default 64, sprite width in pixels (power of two).
REQ-002 SHALL have parameter SPR_H, default 64, sprite height in pixels.
REQ-003 SHALL have parameter KEY_COLOR, default 8'hE3, RGB332 colour treated as transparent.
REQ-004 SHALL have ports: clk  in  1  pixel clock (25 MHz); clr_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: video_on  in  1; hsync  in  1; vsync  in  1; pixel_x  in  10; pixel_y  in  10 (raster timing from the sync generator, same cycle).
REQ-006 SHALL have ports: pos_x  in  10; pos_y  in  10; pos_we  in  1 (sprite top-left request strobe).
REQ-007 SHALL have ports: rom_addr  out  12; rom_data  in  8 (synchronous sprite ROM, 1-cycle read latency).
REQ-008 SHALL have ports: bg_color  in  8; rgb  out  8 (RGB332); hsync_o  out  1; vsync_o  out  1; frame_tick  out  1.

Function
REQ-009 SHALL register frame_tick as a 1-cycle pulse one cycle after vsync falls (vsync_d=1, vsync=0).
REQ-010 SHALL latch pos_x/pos_y into a pending register on any cycle with pos_we=1; last write before frame_tick wins.
REQ-011 SHALL copy pending to active position only in the cycle frame_tick is asserted; active position is constant for the whole visible frame (no tearing).
REQ-012 SHALL, when pos_we and frame_tick coincide, load active from the pre-write pending value and take the new write into pending for the next frame.
REQ-013 SHALL compute stage-1 hit = video_on && ax<=pixel_x<ax+SPR_W && ay<=pixel_y<ay+SPR_H using 11-bit unsigned sums (no wrap at 1023).
REQ-014 SHALL register rom_addr = (pixel_y-ay)*SPR_W + (pixel_x-ax) when hit, else 0, one cycle after inputs.
REQ-015 SHALL register rgb two cycles after inputs: 0 if delayed video_on=0; rom_data if delayed hit and (TRANSPARENCY_EN absent or rom_data!=KEY_COLOR); else bg_color.
REQ-016 SHALL delay hsync and vsync by exactly two cycles to hsync_o/vsync_o so they stay aligned with rgb.
REQ-017 SHALL clip sprites extending past x=639 or y=479; active positions >=640/>=480 produce no hit.
REQ-018 SHALL implement 2-state FSM: WAIT_FRAME (rgb forced 0, pipeline and syncs still run) -> RUN on first frame_tick; RUN holds until reset.

Reset
REQ-019 SHALL on clr_n=0 asynchronously clear rgb, rom_addr, hsync_o, vsync_o, frame_tick, pipeline registers, pending and active positions to 0, and enter WAIT_FRAME.
REQ-020 SHALL, on reset mid-frame, discard the in-flight pixels and resume per REQ-018 after release.

Configuration
REQ-021 SHALL, with macro SPRITE_TRANSPARENCY_EN defined, render bg_color for sprite pixels equal to KEY_COLOR.
REQ-022 SHALL, without SPRITE_TRANSPARENCY_EN, render every sprite pixel from rom_data unmodified and omit the comparator.

Structure
REQ-023 SHALL place RGB332 colour constants (KEY_COLOR default, black), 640/480 active limits and the FSM state encoding in shared package vga_pkg.
REQ-024 SHALL isolate the pending/active double-buffer and frame_tick edge detect in sub-module pos_shadow; rendering pipeline stays in sprite_render.

Verification
REQ-025 Reset, then pos_we with (100,50), run one frame -> rgb=0 throughout first frame, sprite visible from second frame.
REQ-026 Active (100,50), pixel (100,50) video_on=1 -> rom_addr=0 one cycle later, rgb=rom_data two cycles later; pixel (163,113) -> rom_addr=4095.
REQ-027 Active (600,450) -> pixel (639,479) rom_addr=(29*64+39)=1895; pixel (599,450) -> bg_color.
REQ-028 pos_we (200,200) mid-frame -> rendered position unchanged until frame_tick; pos_we coincident with frame_tick -> new value applied one frame later.
REQ-029 SPRITE_TRANSPARENCY_EN defined, rom_data=8'hE3 inside sprite -> rgb=bg_color; undefined -> rgb=8'hE3.
REQ-030 Toggle hsync/vsync at arbitrary cycles -> hsync_o/vsync_o equal inputs delayed exactly 2 cycles; assert clr_n=0 mid-line -> all outputs 0 immediately.
